// File: rtl/aes_trace_pkg.sv
// Shared types and constants for the AES trace sequencer: FSM encoding,
// LFSR polynomial and step function, default seed.
package aes_trace_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WAIT_B = 3'd2,
    ST_RUN    = 3'd3,
    ST_CAP    = 3'd4,
    ST_GAP    = 3'd5
  } state_e;

  localparam logic [127:0] LFSR_POLY    = 128'h87;
  localparam logic [127:0] DEFAULT_SEED = 128'h1;
  localparam int           TMR_W        = 16;

  // Galois step for x^128 + x^7 + x^2 + x + 1
  function automatic logic [127:0] lfsr_next(input logic [127:0] s);
    return {s[126:0], 1'b0} ^ (s[127] ? LFSR_POLY : 128'h0);
  endfunction

  // An all-zero state would lock the LFSR, so it is never loaded
  function automatic logic [127:0] seed_fix(input logic [127:0] s);
    return (s == '0) ? 128'h1 : s;
  endfunction

endpackage

// File: rtl/aes_lfsr128.sv
// 128-bit Galois LFSR plaintext source with seed load and step enable.
module aes_lfsr128
  import aes_trace_pkg::*;
(
  input  logic         clk,
  input  logic         load_i,
  input  logic [127:0] seed_i,
  input  logic         step_i,
  output logic [127:0] state_o,
  output logic [127:0] next_o
);

  logic [127:0] state_q;
  logic [127:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = seed_fix(seed_i);
    end else if (step_i) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  assign state_o = state_q;
  assign next_o  = lfsr_next(state_q);

endmodule

// File: rtl/aes_trace_sequencer.sv
// Drives aes_core_static_128 with LFSR or ciphertext-chained plaintexts,
// frames each op with a scope trigger and counts completed traces.
//
//   state  | meaning
//   IDLE   | waiting for enable_i (blocked while err_o is set)
//   LOAD   | load pulse to the core, trigger raised
//   WAIT_B | waiting for busy to rise, BUSY_TO timeout
//   RUN    | core busy, RUN_TO timeout
//   CAP    | result captured, done pulse, next plaintext prepared
//   GAP    | idle spacing between ops, stop checked at its end
module aes_trace_sequencer
  import aes_trace_pkg::*;
#(
  parameter logic [127:0] SEED       = DEFAULT_SEED,
  parameter int           GAP_CYCLES = 16,
  parameter int           NUM_TRACES = 0,
  parameter int           BUSY_TO    = 8,
  parameter int           RUN_TO     = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable_i,
  input  logic         chain_i,
  input  logic         dec_i,
  output logic         core_load_o,
  output logic [127:0] core_data_o,
  output logic         core_dec_o,
  input  logic         core_busy_i,
  input  logic [127:0] core_data_i,
  output logic [127:0] result_o,
  output logic         done_o,
  output logic         trigger_o,
  output logic [15:0]  count_o,
  output logic         err_o
);

  localparam logic [TMR_W-1:0] GAP_LD  = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TMR_W-1:0] BUSY_LD = TMR_W'(BUSY_TO - 1);
  localparam logic [TMR_W-1:0] RUN_LD  = TMR_W'(RUN_TO - 1);
  localparam logic [15:0]      NUM_LIM = 16'(NUM_TRACES);
  localparam bit               NUM_EN  = (NUM_TRACES != 0);

  state_e           state_q;
  logic [TMR_W-1:0] tmr_q;
  logic             chain_q, dec_q, err_q, load_q, trig_q, done_q;
  logic [127:0]     data_q, result_q;
  logic [15:0]      count_q;

  logic             cap;
  logic [127:0]     lfsr_state, lfsr_nxt;

  // The result is captured on the RUN->CAP edge so it is valid alongside done_o
  assign cap = (state_q == ST_RUN) && !core_busy_i;

  aes_lfsr128 u_lfsr (
    .clk     (clk),
    .load_i  (!rst_n),
    .seed_i  (SEED),
    .step_i  (cap && !chain_q),
    .state_o (lfsr_state),
    .next_o  (lfsr_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      tmr_q    <= '0;
      chain_q  <= 1'b0;
      dec_q    <= 1'b0;
      err_q    <= 1'b0;
      load_q   <= 1'b0;
      trig_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= '0;
      result_q <= '0;
      count_q  <= '0;
    end else begin
      load_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (enable_i && !err_q) begin
            state_q <= ST_LOAD;
            load_q  <= 1'b1;
            trig_q  <= 1'b1;
            chain_q <= chain_i;
            dec_q   <= dec_i;
            count_q <= '0;
            data_q  <= chain_i ? result_q : lfsr_state;
          end
        end
        ST_LOAD: begin
          state_q <= ST_WAIT_B;
          tmr_q   <= BUSY_LD;
        end
        ST_WAIT_B: begin
          if (core_busy_i) begin
            state_q <= ST_RUN;
            tmr_q   <= RUN_LD;
          end else if (tmr_q == '0) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b1;
            trig_q  <= 1'b0;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        ST_RUN: begin
          if (!core_busy_i) begin
            state_q  <= ST_CAP;
            trig_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= core_data_i;
            count_q  <= count_q + 16'd1;
            data_q   <= chain_q ? core_data_i : lfsr_nxt;
          end else if (tmr_q == '0) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b1;
            trig_q  <= 1'b0;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        ST_CAP: begin
          if (NUM_EN && count_q == NUM_LIM) begin
            state_q <= ST_IDLE;
          end else if (GAP_CYCLES == 0) begin
            state_q <= enable_i ? ST_LOAD : ST_IDLE;
            load_q  <= enable_i;
            trig_q  <= enable_i;
          end else begin
            state_q <= ST_GAP;
            tmr_q   <= GAP_LD;
          end
        end
        ST_GAP: begin
          if (tmr_q == '0) begin
            state_q <= enable_i ? ST_LOAD : ST_IDLE;
            load_q  <= enable_i;
            trig_q  <= enable_i;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign core_load_o = load_q;
  assign core_data_o = data_q;
  assign core_dec_o  = dec_q;
  assign result_o    = result_q;
  assign done_o      = done_q;
  assign trigger_o   = trig_q;
  assign count_o     = count_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_aes_trace_sequencer.sv
// Randomised bench for aes_trace_sequencer with a behavioural core and an
// event-level reference model checked every cycle.
module tb_aes_trace_sequencer;

  localparam logic [127:0] SEED1 = 128'h1;
  localparam int           GAP1  = 2;
  localparam int           NUM1  = 3;
  localparam int           BTO   = 8;
  localparam int           RTO   = 64;
  localparam logic [127:0] SEED2 = {1'b1, 127'b0};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable_i = 1'b0, chain_i = 1'b0, dec_i = 1'b0;
  logic         core_busy_i = 1'b0;
  logic [127:0] core_data_i = '0;
  logic         core_load_o, core_dec_o, done_o, trigger_o, err_o;
  logic [127:0] core_data_o, result_o;
  logic [15:0]  count_o;

  logic         en2 = 1'b0, busy2 = 1'b0;
  logic [127:0] cdata2 = '0;
  logic         load2, dec2, done2, trig2, err2;
  logic [127:0] data2, res2;
  logic [15:0]  cnt2;

  always #5 clk = ~clk;

  aes_trace_sequencer #(
    .SEED(SEED1), .GAP_CYCLES(GAP1), .NUM_TRACES(NUM1), .BUSY_TO(BTO), .RUN_TO(RTO)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .chain_i(chain_i), .dec_i(dec_i),
    .core_load_o(core_load_o), .core_data_o(core_data_o), .core_dec_o(core_dec_o),
    .core_busy_i(core_busy_i), .core_data_i(core_data_i), .result_o(result_o),
    .done_o(done_o), .trigger_o(trigger_o), .count_o(count_o), .err_o(err_o)
  );

  aes_trace_sequencer #(
    .SEED(SEED2), .GAP_CYCLES(0), .NUM_TRACES(0), .BUSY_TO(BTO), .RUN_TO(RTO)
  ) u_dut_g0 (
    .clk(clk), .rst_n(rst_n), .enable_i(en2), .chain_i(1'b0), .dec_i(1'b0),
    .core_load_o(load2), .core_data_o(data2), .core_dec_o(dec2),
    .core_busy_i(busy2), .core_data_i(cdata2), .result_o(res2),
    .done_o(done2), .trigger_o(trig2), .count_o(cnt2), .err_o(err2)
  );

  // Behavioural core: busy rises the cycle after load and lasts busy_len cycles
  int           busy_len = 5;
  bit           never_busy = 1'b0;
  logic [127:0] ct_key = '0;
  int           rem1 = 0, rem2 = 0;

  always @(posedge clk) begin
    if (core_load_o) begin
      core_busy_i <= !never_busy;
      rem1        <= busy_len - 1;
      core_data_i <= core_data_o ^ ct_key;
    end else if (core_busy_i) begin
      if (rem1 == 0) core_busy_i <= 1'b0;
      else           rem1 <= rem1 - 1;
    end
  end

  always @(posedge clk) begin
    if (load2) begin
      busy2  <= 1'b1;
      cdata2 <= data2;
    end else begin
      busy2  <= 1'b0;
    end
  end

  int checks = 0, failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [127:0] lfsr_step(input logic [127:0] s);
    return (s << 1) ^ (s[127] ? 128'h87 : 128'h0);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model state
  bit           rst_prev = 1'b0, en_prev = 1'b0, chain_prev = 1'b0, dec_prev = 1'b0;
  logic [127:0] m_lfsr, m_result, exp_pt, hold_pt, op_key;
  logic [15:0]  m_count;
  bit           m_err, m_dec, m_chain, m_idle, in_op, op_nobusy, gap_pending;
  int           idle_from, load_cyc, op_len, next_load_cyc;

  logic [127:0] pt_log[$];
  int           done_log[$];
  logic [127:0] pt2_log[$];
  int           ld2_cyc[$], dn2_cyc[$];

  always @(negedge clk) begin
    bit exp_load, exp_done;
    cyc++;
    if (load2) begin pt2_log.push_back(data2); ld2_cyc.push_back(cyc); end
    if (done2) dn2_cyc.push_back(cyc);
    exp_load = 1'b0;
    exp_done = 1'b0;
    if (!rst_prev) begin
      m_lfsr = SEED1; m_result = '0; m_count = '0; m_err = 0; m_dec = 0;
      m_chain = 0; m_idle = 1; in_op = 0; gap_pending = 0; exp_pt = '0;
      idle_from = cyc;
      chk("rst_data", core_data_o, 128'h0);
    end else begin
      if (in_op && op_nobusy && cyc == load_cyc + BTO + 1) begin
        m_err = 1; in_op = 0; m_idle = 1; idle_from = cyc;
      end
      if (in_op && !op_nobusy && cyc == load_cyc + op_len + 2) begin
        exp_done = 1; in_op = 0;
        m_count  = m_count + 16'd1;
        m_result = exp_pt ^ op_key;
        if (m_chain) exp_pt = m_result;
        else begin m_lfsr = lfsr_step(m_lfsr); exp_pt = m_lfsr; end
        if (m_count == 16'(NUM1)) begin m_idle = 1; idle_from = cyc + 1; end
        else begin gap_pending = 1; next_load_cyc = cyc + GAP1 + 1; end
      end
      if (gap_pending && cyc == next_load_cyc) begin
        gap_pending = 0;
        if (en_prev) exp_load = 1;
        else begin m_idle = 1; idle_from = cyc; end
      end
      if (m_idle && cyc > idle_from && en_prev && !m_err) begin
        m_idle = 0; exp_load = 1; m_chain = chain_prev; m_dec = dec_prev; m_count = '0;
        exp_pt = chain_prev ? m_result : m_lfsr;
      end
      if (exp_load) begin
        in_op = 1; load_cyc = cyc; op_len = busy_len; op_nobusy = never_busy; op_key = ct_key;
        chk("plaintext", core_data_o, exp_pt);
        hold_pt = exp_pt;
      end else if (exp_done) begin
        chk("next_pt", core_data_o, exp_pt);
      end else if (in_op) begin
        chk("data_hold", core_data_o, hold_pt);
      end
    end
    if (core_load_o) pt_log.push_back(core_data_o);
    if (done_o) done_log.push_back(cyc);
    chk("load", core_load_o, exp_load);
    chk("done", done_o, exp_done);
    chk("trigger", trigger_o, in_op);
    chk("err", err_o, m_err);
    chk("count", count_o, m_count);
    chk("result", result_o, m_result);
    chk("dec", core_dec_o, m_dec);
    rst_prev   = rst_n;
    en_prev    = enable_i;
    chain_prev = chain_i;
    dec_prev   = dec_i;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    tick(n);
    rst_n = 1'b1;
  endtask

  task automatic clear_logs();
    pt_log.delete();
    done_log.delete();
  endtask

  task automatic wait_dones(input int n, input int budget);
    int k = 0;
    while (done_log.size() < n && k < budget) begin tick(1); k++; end
    chk("wait_dones", done_log.size() >= n, 1);
  endtask

  task automatic wait_loads(input int n, input int budget);
    int k = 0;
    while (pt_log.size() < n && k < budget) begin tick(1); k++; end
    chk("wait_loads", pt_log.size() >= n, 1);
  endtask

  initial begin
    #1;
    do_reset(3);
    tick(2);

    // GAP_CYCLES=0 instance: MSB-only seed steps to the polynomial, loads back-to-back
    en2 = 1'b1;
    for (int k = 0; k < 50 && pt2_log.size() < 2; k++) tick(1);
    en2 = 1'b0;
    tick(10);
    chk("g0_loads", pt2_log.size() >= 2, 1);
    chk("g0_pt0", pt2_log[0], SEED2);
    chk("g0_pt1", pt2_log[1], 128'h87);
    chk("g0_back2back", ld2_cyc[1] - dn2_cyc[0], 1);
    chk("g0_latency", dn2_cyc[0] - ld2_cyc[0], 3);

    // LFSR run of NUM1 traces with busy=11
    clear_logs();
    busy_len = 11; ct_key = rand128(); chain_i = 1'b0; dec_i = 1'b0; enable_i = 1'b1;
    wait_dones(3, 200);
    enable_i = 1'b0;
    tick(5);
    chk("t1_nloads", pt_log.size(), 3);
    chk("t1_pt0", pt_log[0], 128'h1);
    chk("t1_pt1", pt_log[1], 128'h2);
    chk("t1_pt2", pt_log[2], 128'h4);
    chk("t1_count", count_o, 16'd3);
    chk("t1_spacing", done_log[1] - done_log[0], 11 + 2 + GAP1 + 1);
    chk("t1_idle_trig", trigger_o, 0);

    // Chain mode from a cleared result
    do_reset(2);
    tick(2);
    clear_logs();
    busy_len = $urandom_range(1, 20); ct_key = 128'hFF; chain_i = 1'b1; dec_i = 1'b1;
    enable_i = 1'b1;
    wait_dones(3, 300);
    enable_i = 1'b0;
    tick(5);
    chk("t2_pt0", pt_log[0], 128'h0);
    chk("t2_pt1", pt_log[1], 128'hFF);
    chk("t2_pt2", pt_log[2], 128'h0);
    chk("t2_result", result_o, 128'hFF);
    chk("t2_dec", core_dec_o, 1);

    // Enable dropped while the core is busy
    clear_logs();
    busy_len = 15; ct_key = rand128(); chain_i = 1'b0; dec_i = 1'b0; enable_i = 1'b1;
    wait_loads(1, 50);
    tick(3);
    enable_i = 1'b0;
    tick(40);
    chk("t4_dones", done_log.size(), 1);
    chk("t4_loads", pt_log.size(), 1);
    chk("t4_count", count_o, 16'd1);

    // Reset mid-run, then restart from the seed
    clear_logs();
    busy_len = 15; enable_i = 1'b1;
    wait_loads(1, 50);
    tick(4);
    rst_n = 1'b0; enable_i = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("t5_rst_ctl", {core_load_o, trigger_o, done_o, err_o, core_dec_o}, 0);
    chk("t5_rst_cnt", count_o, 0);
    chk("t5_rst_res", result_o, 0);
    tick(25);
    clear_logs();
    busy_len = $urandom_range(1, 20); enable_i = 1'b1;
    wait_dones(3, 300);
    enable_i = 1'b0;
    tick(5);
    chk("t5_pt_seed", pt_log[0], SEED1);

    // Randomised runs
    for (int r = 0; r < 12; r++) begin
      clear_logs();
      busy_len = $urandom_range(1, 20);
      ct_key   = rand128();
      chain_i  = 1'($urandom_range(0, 1));
      dec_i    = 1'($urandom_range(0, 1));
      enable_i = 1'b1;
      if ($urandom_range(0, 2) == 0) begin
        tick($urandom_range(5, 40));
        enable_i = 1'b0;
      end else begin
        wait_dones(3, 300);
        enable_i = 1'b0;
      end
      tick(60);
    end

    // Core never raises busy: sticky timeout blocks further runs
    clear_logs();
    never_busy = 1'b1; chain_i = 1'b0; enable_i = 1'b1;
    tick(BTO + 6);
    chk("t3_err", err_o, 1);
    chk("t3_nodone", done_log.size(), 0);
    enable_i = 1'b0;
    tick(2);
    enable_i = 1'b1;
    tick(10);
    chk("t3_blocked", pt_log.size(), 1);
    enable_i = 1'b0; never_busy = 1'b0;
    do_reset(1);
    tick(1);
    chk("t3_err_clr", err_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
